p_flags_unit: RTL and testbench
===============================

Name: p_flags_unit

Overview:
- Processor status (P) register, directly downstream of the ALU and its Z unit.
- Consumes per-cycle ALU flag results (carry, overflow, zero, result byte) and data-bus bytes, and commits them to N V D I Z C under microcode control.
- Feeds carry-in and decimal mode back to the ALU input muxing.
- Sequences two-byte word operations so carry and zero span both bytes.

Parameters:
- CMOS_INT_CLEARS_D, 1, interrupt entry (FLG_INTR) also clears D.
- RESET_P, 8'h34, P value after reset (I=1, bit5=1, B=1 for the push image only).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- ready  in  1  CPU advance enable; 0 freezes all state.
- flag_op  in  4  flag command, FLG_* encoding.
- alu_y  in  8  ALU result byte (N source).
- alu_c  in  1  ALU carry_out.
- alu_v  in  1  ALU overflow_out.
- alu_z  in  1  zero from Z unit.
- db_in  in  8  data bus byte (PLP/RTI pull, BIT memory operand).
- word_op  in  1  current ALU cycle belongs to a 16-bit op.
- word_hi  in  1  with word_op: 1 = high byte cycle, 0 = low byte cycle.
- brk_push  in  1  B bit value for the push image.
- so_n  in  1  set-overflow pin, active-low, synchronous to clk.
- p_out  out  8  {N,V,1,1,D,I,Z,C}.
- p_push  out  8  {N,V,1,brk_push,D,I,Z,C}; combinational.
- alu_cin  out  1  carry into ALU.
- dec_mode  out  1  D flag.

Behaviour:
- Reset (reset_n=0 at clk edge): N=V=D=Z=C=0, I=1, word state W_IDLE, wc=0, wz=0, so_q=1.
- Priority: reset > ready=0 (hold everything, including word state) > command.
- All flag updates land on the clk edge of the cycle in which flag_op is presented, with ready=1. p_out reflects them the next cycle. There is no other latency.
- FLG_NONE: no change.
- FLG_NZ: N=alu_y[7], Z=alu_z.
- FLG_NZC: FLG_NZ plus C=alu_c.
- FLG_NVZC: FLG_NZC plus V=alu_v.
- FLG_BIT: N=db_in[7], V=db_in[6], Z=alu_z.
- FLG_PLP: {N,V,D,I,Z,C} = db_in bits {7,6,3,2,1,0}; db_in bits 5 and 4 are ignored.
- FLG_SEC/CLC, FLG_SEI/CLI, FLG_SED/CLD, FLG_CLV: set or clear that single bit.
- FLG_INTR: I=1; D=0 if CMOS_INT_CLEARS_D.
- Word state machine (2 states):
  - W_IDLE: word_op=1 and word_hi=0 and ready moves to W_LO. Latch wc=alu_c and wz=alu_z. P is not updated; flag_op is ignored that cycle.
  - W_LO: word_op=1 and word_hi=1 applies flag_op with Z=alu_z & wz, N and C from the high byte, then returns to W_IDLE.
  - W_LO, non-word cycle: abort. Return to W_IDLE and apply flag_op as a byte op.
  - W_IDLE, word_hi=1: byte op, wz treated as 1.
- alu_cin = wc in W_LO, otherwise C.
- dec_mode = D.
- SO edge detect:
  - so_q <= so_n every clk, independent of ready.
  - so_q=1 and so_n=0 sets V at that edge.
  - It overrides any V write from flag_op in the same cycle.
  - It is ignored while reset_n=0.
- Bits 5 and 4 of p_out are constant 1.

Decomposition:
- Shared include: FLG_* 4-bit command encodings (15 values plus FLG_NONE), P bit-index constants (P_N=7 … P_C=0), reset P constant.
- One sub-module, p_word_seq: word state, wc/wz latches, alu_cin mux.
- Flag register and command decode live in the top.

Test Plan:
- Reset: reset_n=0 for 2 clks, then 1 → p_out=8'h34, alu_cin=0, dec_mode=0.
- FLG_NVZC, alu_y=8'h80, alu_c=1, alu_v=1, alu_z=0 → p_out=8'hF5 (I held); repeat with ready=0 and FLG_CLC → p_out unchanged.
- FLG_PLP, db_in=8'h00 → p_out=8'h30; FLG_BIT, db_in=8'hC0, alu_z=1 → p_out=8'hF2.
- Word op: lo cycle alu_c=1, alu_z=1 → p_out unchanged, alu_cin=1 next cycle; hi cycle FLG_NZC, alu_y=8'h00, alu_z=1, alu_c=0 → Z=1, C=0. Repeat with lo alu_z=0 → Z=0.
- Abort: lo word cycle, then non-word FLG_SEC → state W_IDLE, C=1, alu_cin follows C.
- so_n 1→0 in the same cycle as FLG_CLV → V=1. so_n held low → no further sets after FLG_CLV. Reset with so_n=0 → V=0 after reset.

Source files
------------

// File: rtl/p_flags_unit_pkg.sv
// Shared definitions for the processor status (P) register: flag command
// encodings, P bit positions and the reset image.
package p_flags_unit_pkg;

  typedef enum logic [3:0] {
    FLG_NONE   = 4'd0,
    FLG_NZ     = 4'd1,
    FLG_NZC    = 4'd2,
    FLG_NVZC   = 4'd3,
    FLG_BIT    = 4'd4,
    FLG_PLP    = 4'd5,
    FLG_SEC    = 4'd6,
    FLG_CLC    = 4'd7,
    FLG_SEI    = 4'd8,
    FLG_CLI    = 4'd9,
    FLG_SED    = 4'd10,
    FLG_CLD    = 4'd11,
    FLG_CLV    = 4'd12,
    FLG_INTR   = 4'd13,
    FLG_RSVD_E = 4'd14,
    FLG_RSVD_F = 4'd15
  } flg_op_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_LO   = 1'b1
  } word_state_e;

  localparam int P_N = 7;
  localparam int P_V = 6;
  localparam int P_U = 5;
  localparam int P_B = 4;
  localparam int P_D = 3;
  localparam int P_I = 2;
  localparam int P_Z = 1;
  localparam int P_C = 0;

  localparam logic [7:0] P_RESET = 8'h34;

endpackage

// File: rtl/p_flags_unit_if.sv
// Microcode/ALU-facing bus of the P register: per-cycle flag inputs and the
// status outputs fed back to the datapath.
interface p_flags_unit_if;
  import p_flags_unit_pkg::*;

  logic       ready;
  logic [3:0] flag_op;
  logic [7:0] alu_y;
  logic       alu_c;
  logic       alu_v;
  logic       alu_z;
  logic [7:0] db_in;
  logic       word_op;
  logic       word_hi;
  logic       brk_push;
  logic [7:0] p_out;
  logic [7:0] p_push;
  logic       alu_cin;
  logic       dec_mode;

  modport master (
    output ready, flag_op, alu_y, alu_c, alu_v, alu_z, db_in,
           word_op, word_hi, brk_push,
    input  p_out, p_push, alu_cin, dec_mode
  );

  modport slave (
    input  ready, flag_op, alu_y, alu_c, alu_v, alu_z, db_in,
           word_op, word_hi, brk_push,
    output p_out, p_push, alu_cin, dec_mode
  );

endinterface

// File: rtl/p_flags_unit_word_seq.sv
// Two-byte word sequencer: remembers low-byte carry and zero so the high-byte
// cycle can chain carry into the ALU and report zero across the whole word.
module p_word_seq
  import p_flags_unit_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic ready,
  input  logic word_op,
  input  logic word_hi,
  input  logic alu_c,
  input  logic alu_z,
  input  logic c_flag,
  output logic hold_p,
  output logic eff_z,
  output logic alu_cin
);

  word_state_e state_q, state_d;
  logic        wc_q, wc_d;
  logic        wz_q, wz_d;

  // A low-byte cycle always (re)starts the word; any other advancing cycle
  // returns to idle, with only a true high-byte cycle folding in the low zero.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    wz_d    = wz_q;
    hold_p  = 1'b0;
    eff_z   = alu_z;
    if (ready) begin
      if (word_op && !word_hi) begin
        state_d = W_LO;
        wc_d    = alu_c;
        wz_d    = alu_z;
        hold_p  = 1'b1;
      end else begin
        state_d = W_IDLE;
        if (state_q == W_LO && word_op) begin
          eff_z = alu_z & wz_q;
        end
      end
    end
  end

  assign alu_cin = (state_q == W_LO) ? wc_q : c_flag;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= W_IDLE;
      wc_q    <= 1'b0;
      wz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      wz_q    <= wz_d;
    end
  end

endmodule

// File: rtl/p_flags_unit.sv
// Processor status register: commits ALU and data-bus flag results to
// N V D I Z C under microcode command, with the SO pin edge forcing V.
module p_flags_unit
  import p_flags_unit_pkg::*;
#(
  parameter bit         CMOS_INT_CLEARS_D = 1'b1,
  parameter logic [7:0] RESET_P           = P_RESET
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           so_n,
  p_flags_unit_if.slave  bus
);

  logic n_flag_q, n_flag_d;
  logic v_flag_q, v_flag_d;
  logic d_flag_q, d_flag_d;
  logic i_flag_q, i_flag_d;
  logic z_flag_q, z_flag_d;
  logic c_flag_q, c_flag_d;
  logic so_q, so_d;
  logic hold_p;
  logic eff_z;
  logic alu_cin;
  flg_op_e op;

  assign op = flg_op_e'(bus.flag_op);

  p_word_seq u_word_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .ready   (bus.ready),
    .word_op (bus.word_op),
    .word_hi (bus.word_hi),
    .alu_c   (bus.alu_c),
    .alu_z   (bus.alu_z),
    .c_flag  (c_flag_q),
    .hold_p  (hold_p),
    .eff_z   (eff_z),
    .alu_cin (alu_cin)
  );

  always_comb begin
    n_flag_d = n_flag_q;
    v_flag_d = v_flag_q;
    d_flag_d = d_flag_q;
    i_flag_d = i_flag_q;
    z_flag_d = z_flag_q;
    c_flag_d = c_flag_q;
    so_d     = so_n;
    if (bus.ready && !hold_p) begin
      unique case (op)
        FLG_NZ: begin
          n_flag_d = bus.alu_y[7];
          z_flag_d = eff_z;
        end
        FLG_NZC: begin
          n_flag_d = bus.alu_y[7];
          z_flag_d = eff_z;
          c_flag_d = bus.alu_c;
        end
        FLG_NVZC: begin
          n_flag_d = bus.alu_y[7];
          z_flag_d = eff_z;
          c_flag_d = bus.alu_c;
          v_flag_d = bus.alu_v;
        end
        FLG_BIT: begin
          n_flag_d = bus.db_in[7];
          v_flag_d = bus.db_in[6];
          z_flag_d = eff_z;
        end
        FLG_PLP: begin
          n_flag_d = bus.db_in[P_N];
          v_flag_d = bus.db_in[P_V];
          d_flag_d = bus.db_in[P_D];
          i_flag_d = bus.db_in[P_I];
          z_flag_d = bus.db_in[P_Z];
          c_flag_d = bus.db_in[P_C];
        end
        FLG_SEC: c_flag_d = 1'b1;
        FLG_CLC: c_flag_d = 1'b0;
        FLG_SEI: i_flag_d = 1'b1;
        FLG_CLI: i_flag_d = 1'b0;
        FLG_SED: d_flag_d = 1'b1;
        FLG_CLD: d_flag_d = 1'b0;
        FLG_CLV: v_flag_d = 1'b0;
        FLG_INTR: begin
          i_flag_d = 1'b1;
          if (CMOS_INT_CLEARS_D) begin
            d_flag_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
    // The SO sampler runs even when stalled, so its edge must act then too.
    if (so_q && !so_n) begin
      v_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      n_flag_q <= RESET_P[P_N];
      v_flag_q <= RESET_P[P_V];
      d_flag_q <= RESET_P[P_D];
      i_flag_q <= RESET_P[P_I];
      z_flag_q <= RESET_P[P_Z];
      c_flag_q <= RESET_P[P_C];
      so_q     <= 1'b1;
    end else begin
      n_flag_q <= n_flag_d;
      v_flag_q <= v_flag_d;
      d_flag_q <= d_flag_d;
      i_flag_q <= i_flag_d;
      z_flag_q <= z_flag_d;
      c_flag_q <= c_flag_d;
      so_q     <= so_d;
    end
  end

  always_comb begin
    bus.p_out      = 8'h00;
    bus.p_out[P_N] = n_flag_q;
    bus.p_out[P_V] = v_flag_q;
    bus.p_out[P_U] = 1'b1;
    bus.p_out[P_B] = 1'b1;
    bus.p_out[P_D] = d_flag_q;
    bus.p_out[P_I] = i_flag_q;
    bus.p_out[P_Z] = z_flag_q;
    bus.p_out[P_C] = c_flag_q;
    bus.p_push     = bus.p_out;
    bus.p_push[P_B] = bus.brk_push;
  end

  assign bus.alu_cin  = alu_cin;
  assign bus.dec_mode = d_flag_q;

endmodule

// File: tb/tb_p_flags_unit.sv
// Directed self-checking bench for p_flags_unit: expected P images are queued
// as each step is driven and compared once the clock edge has committed it.
module tb_p_flags_unit;
  import p_flags_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic so_n = 1'b1;

  p_flags_unit_if bus ();

  p_flags_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .so_n    (so_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] p;
    logic [7:0] push;
    logic       cin;
    logic       dec;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  task automatic drive(input flg_op_e op, input logic [7:0] y, input logic c,
                       input logic v, input logic z, input logic [7:0] db,
                       input logic wop, input logic whi);
    bus.flag_op = op;
    bus.alu_y   = y;
    bus.alu_c   = c;
    bus.alu_v   = v;
    bus.alu_z   = z;
    bus.db_in   = db;
    bus.word_op = wop;
    bus.word_hi = whi;
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] ep,
                               input logic ecin, input logic edec);
    exp_t e;
    e.tag  = tag;
    e.p    = ep;
    e.push = {ep[7:5], bus.brk_push, ep[3:0]};
    e.cin  = ecin;
    e.dec  = edec;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    compared++;
    assert (sb.size() > 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      assert (bus.p_out === e.p) else begin
        mismatched++;
        $error("[TB] FAIL %s p_out: got %h expected %h", e.tag, bus.p_out, e.p);
      end
      compared++;
      assert (bus.p_push === e.push) else begin
        mismatched++;
        $error("[TB] FAIL %s p_push: got %h expected %h", e.tag, bus.p_push, e.push);
      end
      compared++;
      assert (bus.alu_cin === e.cin) else begin
        mismatched++;
        $error("[TB] FAIL %s alu_cin: got %b expected %b", e.tag, bus.alu_cin, e.cin);
      end
      compared++;
      assert (bus.dec_mode === e.dec) else begin
        mismatched++;
        $error("[TB] FAIL %s dec_mode: got %b expected %b", e.tag, bus.dec_mode, e.dec);
      end
    end
  endtask

  task automatic step(input string tag, input logic [7:0] ep,
                      input logic ecin, input logic edec);
    applyStimulus(tag, ep, ecin, edec);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.ready    = 1'b1;
    bus.brk_push = 1'b0;
    drive(FLG_NONE, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    reset_n = 1'b0;
    step("reset_a", 8'h34, 1'b0, 1'b0);
    step("reset_b", 8'h34, 1'b0, 1'b0);
    reset_n = 1'b1;
    step("post_reset", 8'h34, 1'b0, 1'b0);

    drive(FLG_NVZC, 8'h80, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("nvzc", 8'hF5, 1'b1, 1'b0);
    bus.ready = 1'b0;
    drive(FLG_CLC, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("stall_clc", 8'hF5, 1'b1, 1'b0);
    bus.ready = 1'b1;

    bus.brk_push = 1'b1;
    drive(FLG_PLP, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("plp_00", 8'h30, 1'b0, 1'b0);
    drive(FLG_BIT, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b0);
    step("bit_c0", 8'hF2, 1'b0, 1'b0);
    bus.brk_push = 1'b0;
    drive(FLG_PLP, 8'h00, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0);
    step("plp_0f", 8'h3F, 1'b1, 1'b1);
    drive(FLG_CLI, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("cli", 8'h3B, 1'b1, 1'b1);
    drive(FLG_INTR, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("intr", 8'h37, 1'b1, 1'b0);
    drive(FLG_CLC, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("clc", 8'h36, 1'b0, 1'b0);
    drive(FLG_SED, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("sed", 8'h3E, 1'b0, 1'b1);
    drive(FLG_CLD, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("cld", 8'h36, 1'b0, 1'b0);
    drive(FLG_NZC, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("nzc_c1", 8'h35, 1'b1, 1'b0);

    drive(FLG_NZC, 8'h80, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    step("word1_lo", 8'h35, 1'b1, 1'b0);
    drive(FLG_NZC, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    step("word1_hi", 8'h36, 1'b0, 1'b0);
    drive(FLG_NZC, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step("word2_lo", 8'h36, 1'b1, 1'b0);
    drive(FLG_NZC, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    step("word2_hi", 8'h34, 1'b0, 1'b0);

    drive(FLG_SEC, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("sec", 8'h35, 1'b1, 1'b0);
    drive(FLG_NONE, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    step("abort_lo", 8'h35, 1'b0, 1'b0);
    drive(FLG_SEC, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("abort_sec", 8'h35, 1'b1, 1'b0);
    drive(FLG_NZC, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    step("idle_hi", 8'h36, 1'b0, 1'b0);

    drive(FLG_NONE, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    step("word3_lo", 8'h36, 1'b1, 1'b0);
    bus.ready = 1'b0;
    drive(FLG_NZC, 8'h80, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    step("word3_stall", 8'h36, 1'b1, 1'b0);
    bus.ready = 1'b1;
    step("word3_hi", 8'hB7, 1'b1, 1'b0);

    so_n = 1'b0;
    drive(FLG_CLV, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("so_edge_clv", 8'hF7, 1'b1, 1'b0);
    step("so_low_clv", 8'hB7, 1'b1, 1'b0);
    drive(FLG_NONE, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("so_low_none", 8'hB7, 1'b1, 1'b0);
    so_n = 1'b1;
    step("so_rise", 8'hB7, 1'b1, 1'b0);
    drive(FLG_NVZC, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("nvzc_v", 8'h74, 1'b0, 1'b0);

    so_n = 1'b0;
    reset_n = 1'b0;
    drive(FLG_NONE, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step("reset_so_a", 8'h34, 1'b0, 1'b0);
    step("reset_so_b", 8'h34, 1'b0, 1'b0);
    so_n = 1'b1;
    reset_n = 1'b1;
    step("reset_so_rel", 8'h34, 1'b0, 1'b0);

    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
